pwd_entry_check: RTL and testbench

//  Parametrised keypad password entry and verification controller for the lock design.

---
 rtl/pwd_pkg.sv | 20 ++
 rtl/pwd_entry_check_if.sv | 32 +++
 rtl/pwd_lock_timer.sv | 38 +++
 rtl/pwd_entry_check.sv | 174 +++++++++++++++++
 tb/tb_pwd_entry_check.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pwd_pkg.sv
// rtl/pwd_pkg.sv - key codes, FSM states and key helpers for the password entry checker
// Purpose: definitions shared by the password entry checker and its testbench.
// Contents: KEY_CONFIRM/KEY_BACK/KEY_CLEAR key codes, state_t enum, is_digit().
package pwd_pkg;

   localparam logic [3:0] KEY_CONFIRM = 4'hA;
   localparam logic [3:0] KEY_BACK    = 4'hB;
   localparam logic [3:0] KEY_CLEAR   = 4'hD;

   typedef enum logic [1:0] {
      ENTRY  = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

endpackage

// File: rtl/pwd_entry_check_if.sv
// rtl/pwd_entry_check_if.sv - keypad/password bus between the lock logic and the entry checker
// Purpose: bundles the key strobe, password load and the status outputs of pwd_entry_check.
// master: drives key_value/key_valid/pwd_load/new_pwd, observes status.
// slave : the checker; drives input_pwd/digit_cnt/saved_pwd/unlock/fail/locked.
interface pwd_entry_check_if #(
   parameter int DIGITS = 4
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   logic [3:0]    key_value;
   logic          key_valid;
   logic          pwd_load;
   logic [W-1:0]  new_pwd;
   logic [W-1:0]  input_pwd;
   logic [CW-1:0] digit_cnt;
   logic [W-1:0]  saved_pwd;
   logic          unlock;
   logic          fail;
   logic          locked;

   modport master (
      output key_value, key_valid, pwd_load, new_pwd,
      input  input_pwd, digit_cnt, saved_pwd, unlock, fail, locked
   );

   modport slave (
      input  key_value, key_valid, pwd_load, new_pwd,
      output input_pwd, digit_cnt, saved_pwd, unlock, fail, locked
   );

endinterface

// File: rtl/pwd_lock_timer.sv
// rtl/pwd_lock_timer.sv - loadable down-counter shared by entry timeout and lockout
// Purpose: counts down from load_val once armed and reports when it has reached zero.
// Ports: clk, rst_n (async, active-low), load (arm with load_val),
//        load_val, restart (disarm, back to idle), zero (armed and count is 0).
module pwd_lock_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             restart,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;
   logic             run;

   // load wins over restart so a key that both ends and starts a countdown re-arms it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (load) begin
         cnt <= load_val;
         run <= 1'b1;
      end else if (restart) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // zero stays high while armed at 0; the owner must restart or reload it.
   assign zero = run && (cnt == '0);

endmodule

// File: rtl/pwd_entry_check.sv
// rtl/pwd_entry_check.sv - keypad password entry, verification and lockout controller
// Purpose: collects DIGITS BCD digits (with backspace/clear), checks them against the saved
//          password on confirm, pulses unlock or fail, locks out after MAX_FAIL fails and
//          discards idle partial entries.
// Ports: clk, rst_n (async, active-low), bus (pwd_entry_check_if.slave).
module pwd_entry_check
   import pwd_pkg::*;
#(
   parameter int                  DIGITS         = 4,
   parameter int                  MAX_FAIL       = 3,
   parameter int                  LOCK_CYCLES    = 1000,
   parameter int                  TIMEOUT_CYCLES = 5000,
   parameter logic [4*DIGITS-1:0] RST_PWD        = {DIGITS{4'h1}}
) (
   input logic                clk,
   input logic                rst_n,
   pwd_entry_check_if.slave   bus
);

   localparam int W    = 4 * DIGITS;
   localparam int CW   = $clog2(DIGITS + 1);
   localparam int FW   = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
   localparam int TMAX = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [CW-1:0] FULL       = CW'(DIGITS);
   localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);
   localparam logic [TW-1:0] LOCK_LD    = TW'(LOCK_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [W-1:0]  pwd_q, pwd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  saved_q, saved_d;
   logic [FW-1:0] fail_cnt, fail_cnt_d;
   logic          unlock_q, unlock_d;
   logic          fail_q, fail_d;
   logic          locked_q, locked_d;

   logic          t_load, t_restart, t_zero;
   logic [TW-1:0] t_val;

   // Shift helpers sized so that DIGITS=1 needs no special-case slicing.
   logic [W+3:0]  shl, shr;
   assign shl = {pwd_q, bus.key_value};
   assign shr = {4'h0, pwd_q};

   pwd_lock_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (t_load),
      .load_val (t_val),
      .restart  (t_restart),
      .zero     (t_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ENTRY;
         pwd_q    <= '0;
         cnt_q    <= '0;
         saved_q  <= RST_PWD;
         fail_cnt <= '0;
         unlock_q <= 1'b0;
         fail_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pwd_q    <= pwd_d;
         cnt_q    <= cnt_d;
         saved_q  <= saved_d;
         fail_cnt <= fail_cnt_d;
         unlock_q <= unlock_d;
         fail_q   <= fail_d;
         locked_q <= locked_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pwd_d      = pwd_q;
      cnt_d      = cnt_q;
      saved_d    = saved_q;
      fail_cnt_d = fail_cnt;
      unlock_d   = 1'b0;
      fail_d     = 1'b0;
      locked_d   = locked_q;
      t_load     = 1'b0;
      t_restart  = 1'b0;
      t_val      = TIMEOUT_LD;

      case (state_q)
         ENTRY: begin
            if (bus.pwd_load) begin
               // Load beats a simultaneous key; the key is simply dropped.
               saved_d   = bus.new_pwd;
               pwd_d     = '0;
               cnt_d     = '0;
               t_restart = 1'b1;
            end else if (bus.key_valid) begin
               if (bus.key_value == KEY_CONFIRM) begin
                  state_d   = CHECK;
                  t_restart = 1'b1;
               end else begin
                  if (is_digit(bus.key_value)) begin
                     if (cnt_q != FULL) begin
                        pwd_d = shl[W-1:0];
                        cnt_d = cnt_q + 1'b1;
                     end
                  end else if (bus.key_value == KEY_BACK) begin
                     if (cnt_q != '0) begin
                        pwd_d = shr[W+3:4];
                        cnt_d = cnt_q - 1'b1;
                     end
                  end else if (bus.key_value == KEY_CLEAR) begin
                     pwd_d = '0;
                     cnt_d = '0;
                  end
                  // Any key restarts the idle countdown while a partial entry exists.
                  if (cnt_d != '0) t_load = 1'b1;
                  else             t_restart = 1'b1;
               end
            end else if (t_zero) begin
               // Idle timeout: drop the partial entry silently.
               pwd_d     = '0;
               cnt_d     = '0;
               t_restart = 1'b1;
            end
         end

         CHECK: begin
            pwd_d = '0;
            cnt_d = '0;
            if ((cnt_q == FULL) && (pwd_q == saved_q)) begin
               unlock_d   = 1'b1;
               fail_cnt_d = '0;
               state_d    = ENTRY;
            end else begin
               fail_d     = 1'b1;
               fail_cnt_d = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 1'b1;
               if (fail_cnt_d >= FAIL_MAX) begin
                  locked_d = 1'b1;
                  state_d  = LOCKED;
                  t_load   = 1'b1;
                  t_val    = LOCK_LD;
               end else begin
                  state_d = ENTRY;
               end
            end
         end

         LOCKED: begin
            if (t_zero) begin
               locked_d   = 1'b0;
               fail_cnt_d = '0;
               state_d    = ENTRY;
               t_restart  = 1'b1;
            end
         end

         default: begin
            state_d = ENTRY;
         end
      endcase
   end

   assign bus.input_pwd = pwd_q;
   assign bus.digit_cnt = cnt_q;
   assign bus.saved_pwd = saved_q;
   assign bus.unlock    = unlock_q;
   assign bus.fail      = fail_q;
   assign bus.locked    = locked_q;

endmodule

// File: tb/tb_pwd_entry_check.sv
// tb/tb_pwd_entry_check.sv - directed self-checking bench for pwd_entry_check
module tb_pwd_entry_check;
   import pwd_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   pwd_entry_check_if #(.DIGITS(4)) bus ();

   pwd_entry_check #(
      .DIGITS         (4),
      .MAX_FAIL       (3),
      .LOCK_CYCLES    (20),
      .TIMEOUT_CYCLES (50),
      .RST_PWD        (16'h1111)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // All stimulus changes and sampling happen at the negedge.
   task automatic press(input logic [3:0] k);
      bus.key_value = k;
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.key_value = 4'h0;
      bus.key_valid = 1'b0;
      bus.pwd_load  = 1'b0;
      bus.new_pwd   = 16'h0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.input_pwd !== 16'h0) begin n_fail++; $display("FAIL rst_input_pwd: got %h expected 0000", bus.input_pwd); end
      n_checks++; if (bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_digit_cnt: got %0d expected 0", bus.digit_cnt); end
      n_checks++; if (bus.saved_pwd !== 16'h1111) begin n_fail++; $display("FAIL rst_saved_pwd: got %h expected 1111", bus.saved_pwd); end
      n_checks++; if ({bus.unlock, bus.fail, bus.locked} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {bus.unlock, bus.fail, bus.locked}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unlock_default;
      repeat (4) press(4'h1);
      press(KEY_CONFIRM);
      n_checks++; if (bus.unlock !== 1'b0) begin n_fail++; $display("FAIL t1_unlock_early: got %b expected 0", bus.unlock); end
      @(negedge clk);
      n_checks++; if (bus.unlock !== 1'b1) begin n_fail++; $display("FAIL t1_unlock: got %b expected 1", bus.unlock); end
      n_checks++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL t1_fail: got %b expected 0", bus.fail); end
      n_checks++; if (bus.input_pwd !== 16'h0) begin n_fail++; $display("FAIL t1_input_clr: got %h expected 0000", bus.input_pwd); end
      n_checks++; if (dut.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL t1_fail_cnt: got %0d expected 0", dut.fail_cnt); end
      @(negedge clk);
      n_checks++; if (bus.unlock !== 1'b0) begin n_fail++; $display("FAIL t1_unlock_pulse: got %b expected 0", bus.unlock); end
   endtask

   task automatic test_edit_keys;
      press(KEY_BACK);
      n_checks++; if (bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL t2_back_empty: got %0d expected 0", bus.digit_cnt); end
      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
      n_checks++; if (bus.input_pwd !== 16'h1234) begin n_fail++; $display("FAIL t2_full_pwd: got %h expected 1234", bus.input_pwd); end
      n_checks++; if (bus.digit_cnt !== 3'd4) begin n_fail++; $display("FAIL t2_full_cnt: got %0d expected 4", bus.digit_cnt); end
      press(KEY_BACK);
      n_checks++; if (bus.input_pwd !== 16'h0123) begin n_fail++; $display("FAIL t2_back_pwd: got %h expected 0123", bus.input_pwd); end
      n_checks++; if (bus.digit_cnt !== 3'd3) begin n_fail++; $display("FAIL t2_back_cnt: got %0d expected 3", bus.digit_cnt); end
      press(4'hC);
      n_checks++; if (bus.input_pwd !== 16'h0123) begin n_fail++; $display("FAIL t2_ignored_key: got %h expected 0123", bus.input_pwd); end
      press(KEY_CLEAR);
      n_checks++; if ({bus.input_pwd, bus.digit_cnt} !== 19'h0) begin n_fail++; $display("FAIL t2_clear: got %h/%0d expected 0000/0", bus.input_pwd, bus.digit_cnt); end
   endtask

   task automatic test_lockout;
      press(4'h1); press(4'h2); press(KEY_CONFIRM);
      @(negedge clk);
      n_checks++; if (bus.fail !== 1'b1) begin n_fail++; $display("FAIL t3_short_fail: got %b expected 1", bus.fail); end
      n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL t3_not_locked1: got %b expected 0", bus.locked); end
      repeat (4) press(4'h9); press(KEY_CONFIRM);
      @(negedge clk);
      n_checks++; if ({bus.fail, bus.locked} !== 2'b10) begin n_fail++; $display("FAIL t3_second_fail: got %b expected 10", {bus.fail, bus.locked}); end
      repeat (4) press(4'h9); press(KEY_CONFIRM);
      @(negedge clk);
      n_checks++; if ({bus.fail, bus.locked, bus.unlock} !== 3'b110) begin n_fail++; $display("FAIL t3_third_fail: got %b expected 110", {bus.fail, bus.locked, bus.unlock}); end
      // locked must hold for exactly 20 sampled cycles while keys and loads are ignored.
      for (int i = 0; i < 20; i++) begin
         n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL t3_locked_c%0d: got %b expected 1", i, bus.locked); end
         bus.key_value = (i == 7) ? KEY_CONFIRM : 4'h1;
         bus.key_valid = 1'b1;
         bus.pwd_load  = (i == 5);
         bus.new_pwd   = 16'h0000;
         @(negedge clk);
      end
      bus.key_valid = 1'b0;
      bus.pwd_load  = 1'b0;
      n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL t3_lock_end: got %b expected 0", bus.locked); end
      n_checks++; if ({bus.input_pwd, bus.digit_cnt} !== 19'h0) begin n_fail++; $display("FAIL t3_keys_ignored: got %h/%0d expected 0000/0", bus.input_pwd, bus.digit_cnt); end
      n_checks++; if (bus.saved_pwd !== 16'h1111) begin n_fail++; $display("FAIL t3_load_ignored: got %h expected 1111", bus.saved_pwd); end
      n_checks++; if (dut.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL t3_fail_cnt_clr: got %0d expected 0", dut.fail_cnt); end
      n_checks++; if ({bus.fail, bus.unlock} !== 2'b00) begin n_fail++; $display("FAIL t3_no_pulse: got %b expected 00", {bus.fail, bus.unlock}); end
   endtask

   task automatic test_pwd_load;
      press(4'h1); press(4'h2);
      bus.new_pwd   = 16'h4321;
      bus.pwd_load  = 1'b1;
      bus.key_value = 4'h7;
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.pwd_load  = 1'b0;
      bus.key_valid = 1'b0;
      n_checks++; if (bus.saved_pwd !== 16'h4321) begin n_fail++; $display("FAIL t4_saved: got %h expected 4321", bus.saved_pwd); end
      n_checks++; if ({bus.input_pwd, bus.digit_cnt} !== 19'h0) begin n_fail++; $display("FAIL t4_key_dropped: got %h/%0d expected 0000/0", bus.input_pwd, bus.digit_cnt); end
      press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(KEY_CONFIRM);
      @(negedge clk);
      n_checks++; if ({bus.unlock, bus.fail} !== 2'b10) begin n_fail++; $display("FAIL t4_new_unlock: got %b expected 10", {bus.unlock, bus.fail}); end
      repeat (4) press(4'h1); press(KEY_CONFIRM);
      @(negedge clk);
      n_checks++; if ({bus.unlock, bus.fail} !== 2'b01) begin n_fail++; $display("FAIL t4_old_fails: got %b expected 01", {bus.unlock, bus.fail}); end
      n_checks++; if (dut.fail_cnt !== 2'd1) begin n_fail++; $display("FAIL t4_fail_cnt: got %0d expected 1", dut.fail_cnt); end
   endtask

   task automatic test_timeout;
      int bad;
      press(4'h5); press(4'h6);
      bad = 0;
      for (int i = 0; i < 49; i++) begin
         @(negedge clk);
         if (bus.input_pwd !== 16'h0056 || bus.fail !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t5_retained_49: got %0d bad cycles expected 0", bad); end
      @(negedge clk);
      n_checks++; if ({bus.input_pwd, bus.digit_cnt} !== 19'h0) begin n_fail++; $display("FAIL t5_timeout_clr: got %h/%0d expected 0000/0", bus.input_pwd, bus.digit_cnt); end
      n_checks++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL t5_no_fail: got %b expected 0", bus.fail); end
      n_checks++; if (dut.fail_cnt !== 2'd1) begin n_fail++; $display("FAIL t5_fail_cnt_kept: got %0d expected 1", dut.fail_cnt); end
      press(4'h5); press(4'h6);
      repeat (48) @(negedge clk);
      press(4'h7);
      repeat (49) @(negedge clk);
      n_checks++; if (bus.input_pwd !== 16'h0567) begin n_fail++; $display("FAIL t5_key_restart: got %h expected 0567", bus.input_pwd); end
      @(negedge clk);
      n_checks++; if (bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL t5_timeout2: got %0d expected 0", bus.digit_cnt); end
   endtask

   task automatic test_reset_mid_op;
      repeat (2) begin
         repeat (4) press(4'h9);
         press(KEY_CONFIRM);
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL t6_pre_locked: got %b expected 1", bus.locked); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL t6_lock_rst_locked: got %b expected 0", bus.locked); end
      n_checks++; if (bus.saved_pwd !== 16'h1111) begin n_fail++; $display("FAIL t6_lock_rst_saved: got %h expected 1111", bus.saved_pwd); end
      n_checks++; if (dut.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL t6_lock_rst_fcnt: got %0d expected 0", dut.fail_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      repeat (4) press(4'h1);
      press(KEY_CONFIRM);
      rst_n = 1'b0;
      #1;
      n_checks++; if ({bus.input_pwd, bus.digit_cnt} !== 19'h0) begin n_fail++; $display("FAIL t6_chk_rst_entry: got %h/%0d expected 0000/0", bus.input_pwd, bus.digit_cnt); end
      @(negedge clk);
      n_checks++; if ({bus.unlock, bus.fail, bus.locked} !== 3'b000) begin n_fail++; $display("FAIL t6_chk_rst_flags: got %b expected 000", {bus.unlock, bus.fail, bus.locked}); end
      rst_n = 1'b1;
      @(negedge clk);
      repeat (4) press(4'h1);
      press(KEY_CONFIRM);
      @(negedge clk);
      n_checks++; if (bus.unlock !== 1'b1) begin n_fail++; $display("FAIL t6_post_rst_unlock: got %b expected 1", bus.unlock); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_unlock_default;
      test_edit_keys;
      test_lockout;
      test_pwd_load;
      test_timeout;
      test_reset_mid_op;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
